// File: rtl/divider_ctrl.sv
// ============================================================================
// Module   : divider_ctrl
// Brief    : Sequencing FSM for the 8-bit / 7-bit restoring-divider datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider_ctrl #(
    parameter int N_ITER = 8,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [6:0] divisorin,
    input  logic       sign,
    output logic       load,
    output logic       add,
    output logic       shift,
    output logic       inbit,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt     = CNT_W'(N_ITER - 1);
    localparam logic [1:0]       c_sel_clear    = 2'd0;
    localparam logic [1:0]       c_sel_addlow   = 2'd1;
    localparam logic [1:0]       c_sel_dividend = 2'd2;
    localparam logic [1:0]       c_sel_hold     = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // While reset is asserted the controls are forced to their idle values,
    // so a start or abort seen during reset cannot disturb the datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        load    = 1'b0;
        add     = 1'b0;
        shift   = 1'b0;
        inbit   = 1'b0;
        sel     = c_sel_hold;
        busy    = 1'b0;
        done    = 1'b0;

        if (reset) begin
            busy = (state_q == ST_ITER);
            if (abort) begin
                sel     = c_sel_clear;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            load    = 1'b1;
                            sel     = c_sel_dividend;
                            shift   = 1'b1;
                            cnt_d   = '0;
                            dbz_d   = (divisorin == 7'd0);
                            state_d = (divisorin == 7'd0) ? ST_DONE : ST_ITER;
                        end
                    end
                    ST_ITER: begin
                        // Restoring step: keep the old partial remainder when
                        // the trial subtraction went negative.
                        shift = 1'b1;
                        sel   = sign ? c_sel_hold : c_sel_addlow;
                        inbit = ~sign;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == c_last_cnt) begin
                            state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign dbz = dbz_q;

endmodule

`default_nettype wire
